// File: rtl/pulse_integrator.sv
`default_nettype none
// ============================================================================
// Module   : pulse_integrator
// Summary  : Triggered window integrator: sums N signed samples and tracks their peak.
// Revision : 1.0
// ============================================================================
module pulse_integrator #(
  parameter int DW = 13,
  parameter int SW = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] din,
  input  logic                 trig,
  input  logic                 enable,
  input  logic [4:0]           win_len,
  input  logic                 clr,
  output logic signed [SW-1:0] sum,
  output logic signed [DW-1:0] peak,
  output logic                 sum_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_INTEG = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic signed [SW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] max_q, max_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [4:0]           len_q, len_d;
  logic signed [SW-1:0] sum_q, sum_d;
  logic signed [DW-1:0] peak_q, peak_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 w_start;
  logic signed [SW-1:0] w_din_ext;

  assign w_start   = (state_q == S_IDLE) && trig && enable;
  assign w_din_ext = {{(SW-DW){din[DW-1]}}, din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      len_q   <= 5'd1;
      sum_q   <= '0;
      peak_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      peak_q  <= peak_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_start) state_d = S_INTEG;
      S_INTEG: if (cnt_q == len_q - 5'd1) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sum_d   = sum_q;
    peak_d  = peak_q;
    valid_d = 1'b0;

    if (w_start) begin
      len_d = (win_len == 5'd0) ? 5'd1 : win_len;
      acc_d = '0;
      cnt_d = '0;
    end

    if (state_q == S_INTEG) begin
      acc_d = acc_q + w_din_ext;
      // The first sample of a window seeds the running maximum.
      max_d = ((cnt_q == 5'd0) || (din > max_q)) ? din : max_q;
      cnt_d = cnt_q + 5'd1;
    end

    if (state_q == S_DONE) begin
      sum_d   = acc_q;
      peak_d  = max_q;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    // A rejected trigger wins over a simultaneous clear.
    if (trig && (state_q != S_IDLE)) ovr_d = 1'b1;
    else if (clr)                    ovr_d = 1'b0;
    else                             ovr_d = ovr_q;
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    sum       = sum_q;
    peak      = peak_q;
    sum_valid = valid_q;
    overrun   = ovr_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_integrator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_integrator
// Summary  : Directed bench with a window-level reference model for pulse_integrator.
// Revision : 1.0
// ============================================================================
module tb_pulse_integrator;

  localparam int DW = 13;
  localparam int SW = 18;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic                 trig = 1'b0;
  logic                 enable = 1'b0;
  logic [4:0]           win_len = 5'd0;
  logic                 clr = 1'b0;
  logic signed [SW-1:0] sum;
  logic signed [DW-1:0] peak;
  logic                 sum_valid;
  logic                 busy;
  logic                 overrun;

  int n_vec = 0;
  int n_bad = 0;

  pulse_integrator #(.DW(DW), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .trig(trig), .enable(enable),
    .win_len(win_len), .clr(clr), .sum(sum), .peak(peak),
    .sum_valid(sum_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Window-level model: remembers start cycle and length, collects the
  // samples of the window, and reduces them with plain arithmetic at the end.
  int      m_cyc, m_start, m_n;
  bit      m_busy, m_valid, m_ovr;
  longint  m_sum, m_peak;
  int      m_q[$];

  function automatic longint f_sum(input int q[$]);
    longint s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  function automatic longint f_max(input int q[$]);
    longint m = q[0];
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0; m_start <= 0; m_n <= 1;
      m_busy <= 1'b0; m_valid <= 1'b0; m_ovr <= 1'b0;
      m_sum <= 0; m_peak <= 0;
      m_q.delete();
    end else begin
      m_cyc   <= m_cyc + 1;
      m_valid <= 1'b0;
      if (!m_busy) begin
        if (trig && enable) begin
          m_busy  <= 1'b1;
          m_start <= m_cyc;
          m_n     <= (win_len == 0) ? 1 : int'(win_len);
          m_q.delete();
        end
      end else if (m_cyc <= m_start + m_n) begin
        m_q.push_back(int'(din));
      end else begin
        m_sum   <= f_sum(m_q);
        m_peak  <= f_max(m_q);
        m_valid <= 1'b1;
        m_busy  <= 1'b0;
      end
      if (m_busy && trig) m_ovr <= 1'b1;
      else if (clr)       m_ovr <= 1'b0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_sum",       longint'(sum),  m_sum);
    chk("cyc_peak",      longint'(peak), m_peak);
    chk("cyc_sum_valid", longint'(sum_valid), longint'(m_valid));
    chk("cyc_busy",      longint'(busy),      longint'(m_busy));
    chk("cyc_overrun",   longint'(overrun),   longint'(m_ovr));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input int len, input int val);
    win_len = 5'(len); trig = 1'b1; step();
    trig = 1'b0; din = DW'(val);
    for (int i = 0; i < ((len == 0) ? 1 : len); i++) step();
    step();
  endtask

  initial begin
    #1;
    chk("reset_sum",     longint'(sum), 0);
    chk("reset_peak",    longint'(peak), 0);
    chk("reset_valid",   longint'(sum_valid), 0);
    chk("reset_busy",    longint'(busy), 0);
    chk("reset_overrun", longint'(overrun), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Basic window, win_len changed mid-window must not matter.
    enable = 1'b1; win_len = 5'd4; trig = 1'b1; step();
    trig = 1'b0; win_len = 5'd7;
    din = 13'sd10; step();
    din = 13'sd20; step();
    din = -13'sd5; step();
    din = 13'sd7;  step();
    chk("basic_no_early_valid", longint'(sum_valid), 0);
    din = 13'sd99; step();
    chk("basic_valid", longint'(sum_valid), 1);
    chk("basic_sum",   longint'(sum), 32);
    chk("basic_peak",  longint'(peak), 20);
    step();
    chk("basic_valid_one_cycle", longint'(sum_valid), 0);
    chk("basic_sum_hold",        longint'(sum), 32);

    // Extremes; enable drops mid-window without aborting it.
    win_len = 5'd31; trig = 1'b1; step();
    trig = 1'b0; din = -13'sd4096;
    for (int i = 0; i < 31; i++) begin
      if (i == 10) enable = 1'b0;
      step();
    end
    step();
    chk("neg_extreme_sum",  longint'(sum), -126976);
    chk("neg_extreme_peak", longint'(peak), -4096);
    enable = 1'b1;
    run_window(31, 4095);
    chk("pos_extreme_sum",  longint'(sum), 126945);
    chk("pos_extreme_peak", longint'(peak), 4095);

    // win_len = 0 behaves as a single-sample window.
    win_len = 5'd0; trig = 1'b1; step();
    trig = 1'b0; din = -13'sd3; step();
    step();
    chk("len0_valid", longint'(sum_valid), 1);
    chk("len0_sum",   longint'(sum), -3);
    chk("len0_peak",  longint'(peak), -3);

    // trig with enable low in IDLE is ignored quietly.
    enable = 1'b0; trig = 1'b1; step(); trig = 1'b0; step();
    chk("disabled_trig_busy",    longint'(busy), 0);
    chk("disabled_trig_overrun", longint'(overrun), 0);
    enable = 1'b1;

    // Overrun: triggers in INTEG and in DONE.
    win_len = 5'd3; trig = 1'b1; step();
    trig = 1'b0; din = 13'sd1; step();
    trig = 1'b1; din = 13'sd2; step();
    trig = 1'b0; din = 13'sd3; step();
    trig = 1'b1; step();
    trig = 1'b0; step();
    chk("ovr_window_sum", longint'(sum), 6);
    chk("ovr_flag",       longint'(overrun), 1);
    win_len = 5'd2; trig = 1'b1; step();
    trig = 1'b1; clr = 1'b1; din = 13'sd4; step();
    chk("ovr_set_beats_clr", longint'(overrun), 1);
    trig = 1'b0; clr = 1'b1; din = 13'sd5; step();
    chk("ovr_clr", longint'(overrun), 0);
    clr = 1'b0; step();
    chk("ovr_second_sum", longint'(sum), 9);

    // Reset mid-window discards the window.
    win_len = 5'd8; trig = 1'b1; step();
    trig = 1'b0; din = 13'sd11; step();
    trig = 1'b1; din = 13'sd12; step();
    trig = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sum",     longint'(sum), 0);
    chk("async_rst_peak",    longint'(peak), 0);
    chk("async_rst_busy",    longint'(busy), 0);
    chk("async_rst_overrun", longint'(overrun), 0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("no_valid_after_rst", longint'(sum_valid), 0);
    end

    // Back-to-back windows.
    win_len = 5'd2; trig = 1'b1; step();
    trig = 1'b0; din = 13'sd5; step();
    din = 13'sd6; step();
    step();
    chk("b2b_first_valid", longint'(sum_valid), 1);
    chk("b2b_first_sum",   longint'(sum), 11);
    trig = 1'b1; step();
    trig = 1'b0; din = -13'sd7; step();
    din = 13'sd100; step();
    chk("b2b_gap_no_valid", longint'(sum_valid), 0);
    step();
    chk("b2b_second_valid", longint'(sum_valid), 1);
    chk("b2b_second_sum",   longint'(sum), 93);
    chk("b2b_second_peak",  longint'(peak), 100);
    chk("b2b_overrun",      longint'(overrun), 0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pulse_integrator.md
PULSE_INTEGRATOR -- requirements
Module: pulse_integrator

Interface
REQ-001 SHALL have parameter DW, default 13, meaning input sample width, two's complement.
REQ-002 SHALL have parameter SW, default 18, meaning sum width; DW+5, never overflows for 31 samples.
REQ-003 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port din, input, DW signed, delayed sample stream from the upstream programmable delay line.
REQ-006 SHALL have port trig, input, 1, window-start request, sampled each edge.
REQ-007 SHALL have port enable, input, 1, arms trigger acceptance.
REQ-008 SHALL have port win_len, input, 5, window length in samples; 0 treated as 1.
REQ-009 SHALL have port clr, input, 1, clears overrun flag.
REQ-010 SHALL have port sum, output, SW signed, registered window sum.
REQ-011 SHALL have port peak, output, DW signed, registered maximum sample in window.
REQ-012 SHALL have port sum_valid, output, 1, one-cycle strobe marking new sum/peak.
REQ-013 SHALL have port busy, output, 1, high in INTEG and DONE states.
REQ-014 SHALL have port overrun, output, 1, sticky flag for rejected trigger.

Function
REQ-015 SHALL implement states IDLE, INTEG, DONE, encoded in registers, busy derived from state.
REQ-016 IDLE->INTEG SHALL occur at edge k where trig=1 and enable=1; win_len latched at edge k (N = max(win_len,1)); accumulator and sample counter cleared at edge k.
REQ-017 In INTEG the block SHALL add sign-extended din at edges k+1 .. k+N, exactly N samples, and track signed max of those samples (initial max = first sample).
REQ-018 INTEG->DONE SHALL occur at edge k+N; DONE->IDLE at edge k+N+1.
REQ-019 At edge k+N+1 sum and peak SHALL load final values and sum_valid SHALL be high for exactly that following cycle.
REQ-020 sum and peak SHALL hold between windows; intermediate accumulation SHALL never appear on sum/peak.
REQ-021 Changes to win_len during INTEG or DONE SHALL not affect the running window.
REQ-022 trig=1 at any edge while state is INTEG or DONE SHALL be ignored and SHALL set overrun.
REQ-023 trig=1 with enable=0 in IDLE SHALL be ignored without setting overrun.
REQ-024 enable falling during INTEG SHALL not abort the window.
REQ-025 clr=1 SHALL clear overrun at the next edge; simultaneous set and clr SHALL leave overrun=1.
REQ-026 Summation SHALL be full-precision two's complement; no saturation needed (|sum| <= 31*4096 < 2^17).
REQ-027 A trig accepted in IDLE on the edge directly after DONE SHALL start a new window normally (back-to-back windows, one idle cycle minimum).

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, sum=0, peak=0, sum_valid=0, overrun=0, accumulator=0, counter=0, regardless of clk.
REQ-029 Reset asserted mid-window SHALL discard that window; no sum_valid SHALL follow release.
REQ-030 After rst_n rises, first trig SHALL be accepted no earlier than the first rising edge with rst_n=1.

Verification
REQ-031 Basic: enable=1, win_len=4, trig pulse, din=10,20,-5,7 on next 4 edges -> sum=32, peak=20, sum_valid one cycle, 5 cycles after trig edge.
REQ-032 Extremes: win_len=31, din=-4096 constant -> sum=-126976; then din=+4095 -> sum=126945, peak=4095.
REQ-033 win_len=0, din=-3 -> N=1, sum=-3, peak=-3, sum_valid 2 cycles after trig edge.
REQ-034 Overrun: trig during INTEG and in DONE -> windows unaffected, overrun=1; clr with simultaneous trig in INTEG -> overrun stays 1; clr alone -> 0.
REQ-035 Reset mid-window (win_len=8, rst_n low at sample 3) -> all outputs 0 asynchronously, no sum_valid after release.
REQ-036 Back-to-back: trig on first IDLE edge after DONE, win_len=2 both -> two sum_valid strobes 4 cycles apart, correct independent sums.
